// File: rtl/bus_cmd_pkg.sv
// Shared command-bus definitions used by the memory responder and the accelerator FSMs.
package bus_cmd_pkg;

    // Bus IDs
    localparam logic [1:0] MEM_ID = 2'b00;
    localparam logic [1:0] SHA_ID = 2'b11;

    // Command opcodes; any value with bit 1 set is illegal
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01
    } bus_op_e;

    // Field offsets inside the 8-bit cmd byte
    localparam int CMD_W       = 8;
    localparam int CMD_OP_LSB  = 0;
    localparam int CMD_DST_LSB = 2;
    localparam int CMD_SRC_LSB = 4;

    // ack_out bit positions
    localparam int ACK_OK_BIT  = 0;
    localparam int ACK_ERR_BIT = 2;

    // Responder state encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_FETCH = 3'd1,
        ST_RD_SEND  = 3'd2,
        ST_WR_RECV  = 3'd3,
        ST_ACK      = 3'd4
    } rsp_state_e;

endpackage

// File: rtl/mem_cmd_responder.sv
// Memory-side command responder: streams a block between the SRAM and the data bus,
// then acknowledges the initiator with a single-cycle ok/err pulse.
module mem_cmd_responder
    import bus_cmd_pkg::*;
#(
    parameter int         ADDRW       = 24,
    parameter logic [1:0] MY_ID       = MEM_ID,
    parameter int         BLOCK_BYTES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [ADDRW+7:0]   data_in,
    output logic               ready_out,
    output logic               bus_req,
    input  logic               bus_grant,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic [ADDRW-1:0]   mem_addr,
    output logic               mem_rd_en,
    input  logic [7:0]         mem_rdata,
    output logic               mem_wr_en,
    output logic [7:0]         mem_wdata,
    output logic [2:0]         ack_out
);

    localparam int              CNTW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(BLOCK_BYTES - 1);

    // Command word fields
    logic [ADDRW-1:0] cmd_addr;
    logic [1:0]       cmd_op;
    logic [1:0]       cmd_dst;
    logic [1:0]       cmd_src;

    assign cmd_addr = data_in[ADDRW+7:CMD_W];
    assign cmd_op   = data_in[CMD_OP_LSB  +: 2];
    assign cmd_dst  = data_in[CMD_DST_LSB +: 2];
    assign cmd_src  = data_in[CMD_SRC_LSB +: 2];

    rsp_state_e       state_q,  state_d;
    logic [CNTW-1:0]  cnt_q,    cnt_d;
    logic             err_q,    err_d;
    logic             rfresh_q, rfresh_d;   // first RD_SEND cycle: SRAM output is live
    logic             rdy_q;                // holds ready_out low until one clock after reset
    logic [ADDRW-1:0] addr_q,   addr_d;
    logic [1:0]       src_q,    src_d;
    logic [1:0]       op_q,     op_d;
    logic [7:0]       rbyte_q,  rbyte_d;

    logic [ADDRW-1:0] blk_addr;
    logic [7:0]       tx_byte;

    // Address wraps naturally modulo 2^ADDRW
    assign blk_addr = addr_q + ADDRW'(cnt_q);
    // Bypass SRAM output on the first send cycle, then replay the captured byte
    assign tx_byte  = rfresh_q ? mem_rdata : rbyte_q;

    // Reserved cmd bits and the latched src/op are kept for debug visibility only
    logic unused_bits;
    assign unused_bits = ^{data_in[7:6], src_q, op_q};

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rfresh_d  = 1'b0;
        addr_d    = addr_q;
        src_d     = src_q;
        op_d      = op_q;
        rbyte_d   = rbyte_q;
        ready_out = 1'b0;
        bus_req   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = 8'h00;
        ack_out   = 3'b000;

        unique case (state_q)
            ST_IDLE: begin
                ready_out = rdy_q;
                if (valid_in && rdy_q && (cmd_dst == MY_ID)) begin
                    addr_d = cmd_addr;
                    src_d  = cmd_src;
                    op_d   = cmd_op;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (cmd_op == OP_READ) begin
                        state_d = ST_RD_FETCH;
                    end else if (cmd_op == OP_WRITE) begin
                        state_d = ST_WR_RECV;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_RD_FETCH: begin
                bus_req   = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = blk_addr;
                rfresh_d  = 1'b1;
                state_d   = ST_RD_SEND;
            end
            ST_RD_SEND: begin
                bus_req  = 1'b1;
                tx_data  = tx_byte;
                tx_valid = bus_grant;
                rbyte_d  = tx_byte;
                if (bus_grant && tx_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = cnt_q + CNTW'(1);
                        state_d = ST_RD_FETCH;
                    end
                end
            end
            ST_WR_RECV: begin
                rx_ready = 1'b1;
                mem_addr = blk_addr;
                if (rx_valid) begin
                    mem_wr_en = 1'b1;
                    mem_wdata = rx_data;
                    if (cnt_q == LAST) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ST_ACK: begin
                ack_out[ACK_OK_BIT]  = ~err_q;
                ack_out[ACK_ERR_BIT] = err_q;
                state_d              = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state: asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rfresh_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rfresh_q <= rfresh_d;
            rdy_q    <= 1'b1;
        end
    end

    // Datapath holding registers: only meaningful after a command is accepted
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        src_q   <= src_d;
        op_q    <= op_d;
        rbyte_q <= rbyte_d;
    end

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed bench for mem_cmd_responder with a behavioural SRAM model.
module tb_mem_cmd_responder;
    import bus_cmd_pkg::*;

    localparam int ADDRW = 24;
    localparam int BB    = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_in = 1'b0;
    logic [ADDRW+7:0] data_in = '0;
    logic             ready_out;
    logic             bus_req;
    logic             bus_grant = 1'b0;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_ready;
    logic [ADDRW-1:0] mem_addr;
    logic             mem_rd_en;
    logic [7:0]       mem_rdata = 8'h00;
    logic             mem_wr_en;
    logic [7:0]       mem_wdata;
    logic [2:0]       ack_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] wmem [int];
    int         wr_count = 0;

    logic [48:0] outs_all;
    assign outs_all = {ready_out, bus_req, tx_valid, tx_data, rx_ready, mem_addr,
                       mem_rd_en, mem_wr_en, mem_wdata, ack_out};

    mem_cmd_responder #(.ADDRW(ADDRW), .MY_ID(MEM_ID), .BLOCK_BYTES(BB)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out), .bus_req(bus_req), .bus_grant(bus_grant),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .ack_out(ack_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] cmdw(input logic [23:0] a, input logic [1:0] src,
                                         input logic [1:0] dst, input logic [1:0] op);
        return {a, 2'b00, src, dst, op};
    endfunction

    // SRAM model: one-cycle read latency, byte writes logged
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= pat(mem_addr);
        if (mem_wr_en) begin
            wmem[int'(mem_addr)] = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_read(input logic [23:0] base, input string tag, input bit stalls,
                            input int exp_ack);
        logic [7:0]  got [$];
        logic [23:0] ra [$];
        int          ack_cyc = -1;
        logic [2:0]  ack_val = 3'b000;
        int          ack_n = 0;
        int          stab_err = 0;
        int          bad_b = 0;
        int          bad_a = 0;
        bit          pend = 1'b0;
        logic [7:0]  pv = 8'h00;
        bit          send;
        logic [23:0] e;
        data_in   = cmdw(base, 2'b11, MEM_ID, OP_READ);
        valid_in  = 1'b1;
        bus_grant = 1'b1;
        tx_ready  = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            valid_in = 1'b0;
            if (stalls) begin
                bus_grant = !(k >= 10 && k <= 12);
                tx_ready  = !(k >= 21 && k <= 22);
            end
            #1;
            if (mem_rd_en) ra.push_back(mem_addr);
            send = bus_req && !mem_rd_en;
            if (send) begin
                if (tx_valid !== bus_grant) stab_err++;
                if (pend && tx_data !== pv) stab_err++;
                if (tx_valid && tx_ready) begin
                    got.push_back(tx_data);
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pv   = tx_data;
                end
            end
            if (ack_out != 3'b000) begin
                ack_n++;
                if (ack_cyc < 0) begin
                    ack_cyc = k;
                    ack_val = ack_out;
                end
            end
            if (ack_cyc > 0 && k >= ack_cyc + 1) break;
        end
        bus_grant = 1'b1;
        tx_ready  = 1'b1;
        for (int i = 0; i < BB; i++) begin
            e = base + 24'(i);
            if (i >= got.size() || got[i] !== pat(e)) bad_b++;
            if (i >= ra.size() || ra[i] !== e) bad_a++;
        end
        chk({tag, " ack_cycle"}, 64'(ack_cyc), 64'(exp_ack));
        chk({tag, " ack_value"}, 64'(ack_val), 64'(3'b001));
        chk({tag, " ack_pulses"}, 64'(ack_n), 64'd1);
        chk({tag, " byte_count"}, 64'(got.size()), 64'(BB));
        chk({tag, " byte_errs"}, 64'(bad_b), 64'd0);
        chk({tag, " fetch_count"}, 64'(ra.size()), 64'(BB));
        chk({tag, " addr_errs"}, 64'(bad_a), 64'd0);
        chk({tag, " hold_errs"}, 64'(stab_err), 64'd0);
        chk({tag, " ready_after"}, 64'(ready_out), 64'd1);
    endtask

    initial begin
        int         idx;
        int         wbase;
        int         ack_cyc;
        logic [2:0] ack_val;
        int         bad;

        // Reset state
        #1;
        chk("rst outputs", 64'(outs_all), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst release ready_lo", 64'(ready_out), 64'd0);
        step();
        #1;
        chk("rst release ready_hi", 64'(ready_out), 64'd1);
        chk("rst release ack", 64'(ack_out), 64'd0);

        // Nominal READ
        run_read(24'h000100, "rd", 1'b0, 65);

        // Reset in the middle of a READ
        data_in  = cmdw(24'h000300, 2'b11, MEM_ID, OP_READ);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        #1;
        chk("midrst busy", 64'(bus_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst outputs", 64'(outs_all), 64'd0);
        step();
        #1;
        chk("midrst held", 64'(outs_all), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst ready_lo", 64'(ready_out), 64'd0);
        step();
        #1;
        chk("midrst ready_hi", 64'(ready_out), 64'd1);
        chk("midrst no_ack", 64'(ack_out), 64'd0);

        // WRITE with rx_valid toggling every cycle
        wbase    = wr_count;
        data_in  = cmdw(24'h000040, 2'b11, MEM_ID, OP_WRITE);
        valid_in = 1'b1;
        idx      = 0;
        ack_cyc  = -1;
        ack_val  = 3'b000;
        for (int k = 1; k <= 200; k++) begin
            step();
            valid_in = 1'b0;
            rx_valid = (k % 2 == 1) && (idx < BB);
            rx_data  = 8'(idx);
            #1;
            if (rx_valid && rx_ready) idx++;
            if (ack_out != 3'b000 && ack_cyc < 0) begin
                ack_cyc = k;
                ack_val = ack_out;
            end
            if (ack_cyc > 0 && k >= ack_cyc + 1) break;
        end
        rx_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < BB; i++) begin
            if (!wmem.exists(32'h40 + i) || wmem[32'h40 + i] !== 8'(i)) bad++;
        end
        chk("wr ack_cycle", 64'(ack_cyc), 64'd64);
        chk("wr ack_value", 64'(ack_val), 64'(3'b001));
        chk("wr write_count", 64'(wr_count - wbase), 64'(BB));
        chk("wr data_errs", 64'(bad), 64'd0);
        chk("wr ready_after", 64'(ready_out), 64'd1);

        // Command for another ID is ignored
        data_in  = cmdw(24'h000123, 2'b00, SHA_ID, OP_READ);
        valid_in = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            if (ready_out !== 1'b1 || ack_out !== 3'b000 || bus_req !== 1'b0 ||
                mem_rd_en !== 1'b0 || rx_ready !== 1'b0) bad++;
        end
        valid_in = 1'b0;
        chk("foreign ignored", 64'(bad), 64'd0);

        // Illegal opcode: error ack one cycle after accept, no memory access
        wbase    = wr_count;
        data_in  = cmdw(24'h000000, 2'b11, MEM_ID, 2'b10);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        #1;
        chk("illegal ack", 64'(ack_out), 64'(3'b100));
        chk("illegal ready", 64'(ready_out), 64'd0);
        chk("illegal memops", 64'({mem_rd_en, mem_wr_en}), 64'd0);
        step();
        #1;
        chk("illegal ack_clear", 64'(ack_out), 64'd0);
        chk("illegal ready_back", 64'(ready_out), 64'd1);
        chk("illegal no_writes", 64'(wr_count - wbase), 64'd0);

        // Address wrap across the top of memory
        run_read(24'hFFFFF0, "wrap", 1'b0, 65);

        // Grant loss and sink backpressure mid-READ
        run_read(24'h000200, "stall", 1'b1, 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
